// File: rtl/id_hazard_if.sv
// ID-stage hazard control bundle: decoder/EX-stage status in, pipeline
// steering and multi-cycle FP unit status out.
interface id_hazard_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_writes_rd;
  logic        id_rs1_fp;
  logic        id_rs2_fp;
  logic        id_rd_fp;
  logic        id_is_mc;
  logic        id_jal;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_rd_fp;
  logic        ex_redirect;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        bubble_ex;
  logic        mc_start;
  logic        mc_busy;
  logic        mc_done;
  logic [4:0]  mc_rd;
  logic [31:0] fp_pending;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_writes_rd, id_rs1_fp, id_rs2_fp, id_rd_fp, id_is_mc, id_jal,
           ex_mem_read, ex_rd, ex_rd_fp, ex_redirect,
    input  stall_if, stall_id, flush_id, bubble_ex,
           mc_start, mc_busy, mc_done, mc_rd, fp_pending
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_writes_rd, id_rs1_fp, id_rs2_fp, id_rd_fp, id_is_mc, id_jal,
           ex_mem_read, ex_rd, ex_rd_fp, ex_redirect,
    output stall_if, stall_id, flush_id, bubble_ex,
           mc_start, mc_busy, mc_done, mc_rd, fp_pending
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage interlock for the RV32IF core: load-use, FP scoreboard and
// structural hazards, plus the scheduler for the shared FDIV/FSQRT unit.
module id_hazard_ctrl #(
  parameter int MC_CYCLES = 12
) (
  input logic        clk,
  input logic        rst,
  id_hazard_if.slave hz
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         mc_rd_q, mc_rd_d;
  logic [31:0]        pend_q, pend_d;

  logic               rd_is_fp;
  logic               rd_written;
  logic               load_use;
  logic               sb_hazard;
  logic               struct_hazard;
  logic               stall;
  logic               issue;

  logic               stall_if_c;
  logic               stall_id_c;
  logic               flush_id_c;
  logic               bubble_ex_c;

  // Same architectural register; integer x0 is hardwired and never aliases.
  function automatic logic reg_eq(input logic [4:0] a, input logic a_fp,
                                  input logic [4:0] b, input logic b_fp);
    return (a == b) && (a_fp == b_fp) && (a_fp || (a != 5'd0));
  endfunction

  function automatic logic fp_pending_hit(input logic        used,
                                          input logic [4:0]  r,
                                          input logic        r_fp,
                                          input logic [31:0] pend);
    return used && r_fp && pend[r];
  endfunction

  // FDIV/FSQRT always write an FP rd even if the decoder flags are sparse.
  assign rd_is_fp   = hz.id_rd_fp | hz.id_is_mc;
  assign rd_written = hz.id_writes_rd | hz.id_is_mc;

  always_comb begin
    load_use = hz.ex_mem_read &&
               ((hz.id_uses_rs1 && reg_eq(hz.id_rs1, hz.id_rs1_fp, hz.ex_rd, hz.ex_rd_fp)) ||
                (hz.id_uses_rs2 && reg_eq(hz.id_rs2, hz.id_rs2_fp, hz.ex_rd, hz.ex_rd_fp)));

    sb_hazard = fp_pending_hit(hz.id_uses_rs1, hz.id_rs1, hz.id_rs1_fp, pend_q) ||
                fp_pending_hit(hz.id_uses_rs2, hz.id_rs2, hz.id_rs2_fp, pend_q) ||
                fp_pending_hit(rd_written,     hz.id_rd,  rd_is_fp,     pend_q);

    struct_hazard = hz.id_is_mc && (state_q != IDLE);

    stall = hz.id_valid && (load_use || sb_hazard || struct_hazard);
    issue = hz.id_valid && hz.id_is_mc && !stall && !hz.ex_redirect;
  end

  // Steering priority: EX redirect, then interlock stall, then JAL flush.
  always_comb begin
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    flush_id_c  = 1'b0;
    bubble_ex_c = 1'b0;
    if (hz.ex_redirect) begin
      flush_id_c  = 1'b1;
      bubble_ex_c = 1'b1;
    end else if (stall) begin
      stall_if_c  = 1'b1;
      stall_id_c  = 1'b1;
      bubble_ex_c = 1'b1;
    end else if (hz.id_valid && hz.id_jal) begin
      flush_id_c  = 1'b1;
    end
  end

  // Redirects never touch the FSM: an in-flight op is older than the branch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d           = BUSY;
          cnt_d             = CNT_W'(MC_CYCLES - 1);
          mc_rd_d           = hz.id_rd;
          pend_d[hz.id_rd]  = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = WB;
        end
      end
      WB: begin
        state_d          = IDLE;
        pend_d[mc_rd_q]  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mc_rd_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_rd_q <= mc_rd_d;
      pend_q  <= pend_d;
    end
  end

  assign hz.stall_if   = stall_if_c;
  assign hz.stall_id   = stall_id_c;
  assign hz.flush_id   = flush_id_c;
  assign hz.bubble_ex  = bubble_ex_c;
  assign hz.mc_start   = issue;
  assign hz.mc_busy    = (state_q != IDLE);
  assign hz.mc_done    = (state_q == WB);
  assign hz.mc_rd      = mc_rd_q;
  assign hz.fp_pending = pend_q;

  a_issue_from_idle : assert property (@(posedge clk) disable iff (rst)
    issue |-> (state_q == IDLE));
  a_wb_returns_idle : assert property (@(posedge clk) disable iff (rst)
    (state_q == WB) |=> (state_q == IDLE));

endmodule
